// File: rtl/background_mem_arbiter.sv
// Background memory arbiter.
//
// Shares one single-port background byte memory (640x480, one byte per pixel)
// between a display fetch port and a CPU port. One requester at most is granted
// each cycle. The display has priority, but after STARVE_LIMIT consecutive
// display grants taken while the CPU was waiting, the CPU is forced through.
// Grants are combinational, so back-to-back accesses run at one per cycle.
// Read data returns one cycle after the grant.
//
// Ports:
//   clk, reset       single clock; asynchronous active-high reset
//   disp_req/addr    display fetch request and byte address (dropped if not granted)
//   disp_ack         display granted this cycle
//   disp_rvalid/rdata display read data, one cycle after disp_ack
//   cpu_req/write/addr/wdata  CPU request, held by the CPU until accepted
//   cpu_waitrequest  CPU request not accepted this cycle (also high in reset)
//   cpu_rvalid/rdata CPU read data, one cycle after a read grant
//   mem_*            memory drive; mem_readdata is valid one cycle after the address
//
// Addresses >= DEPTH complete normally on the request side but never select the
// memory: writes are dropped, reads return 0x00.

module background_mem_arbiter #(
   parameter int unsigned DEPTH        = 307200,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        disp_req,
   input  logic [18:0] disp_addr,
   output logic        disp_ack,
   output logic        disp_rvalid,
   output logic [7:0]  disp_rdata,

   input  logic        cpu_req,
   input  logic        cpu_write,
   input  logic [18:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_waitrequest,
   output logic        cpu_rvalid,
   output logic [7:0]  cpu_rdata,

   output logic [18:0] mem_address,
   output logic        mem_chipselect,
   output logic        mem_write,
   output logic [7:0]  mem_writedata,
   output logic        mem_clken,
   input  logic [7:0]  mem_readdata
);

   localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

   // Arbitration state
   logic [7:0]  starve_cnt_q, starve_cnt_d;
   logic        cpu_forced;
   logic        cpu_grant;
   logic        disp_grant;
   logic        any_grant;

   // Address decode
   logic        disp_in_range;
   logic        cpu_in_range;
   logic        win_in_range;
   logic [18:0] win_addr;

   // Memory bus hold registers (bus keeps its last value when idle)
   logic [18:0] addr_hold_q;
   logic [7:0]  wdata_hold_q;

   // Read return pipeline
   logic        disp_rvalid_q;
   logic        disp_oor_q;
   logic        cpu_rvalid_q;
   logic        cpu_oor_q;

   assign disp_in_range = 32'(disp_addr) < DEPTH;
   assign cpu_in_range  = 32'(cpu_addr) < DEPTH;

   // ------------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------------
   always_comb begin
      cpu_forced = (starve_cnt_q == StarveMax);
      // Reset gates the grants so nothing reaches the memory while in reset.
      cpu_grant  = !reset && cpu_req && (!disp_req || cpu_forced);
      disp_grant = !reset && disp_req && !cpu_grant;
      any_grant  = cpu_grant || disp_grant;

      win_addr     = cpu_grant ? cpu_addr : disp_addr;
      win_in_range = cpu_grant ? cpu_in_range : disp_in_range;
   end

   // ------------------------------------------------------------------------
   // Starvation counter: counts display wins taken while the CPU waited.
   // ------------------------------------------------------------------------
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (cpu_grant) begin
         starve_cnt_d = '0;
      end else if (disp_grant && cpu_req && (starve_cnt_q < StarveMax)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Requester-side outputs
   // ------------------------------------------------------------------------
   always_comb begin
      disp_ack        = disp_grant;
      cpu_waitrequest = reset || (cpu_req && !cpu_grant);

      disp_rvalid = disp_rvalid_q;
      cpu_rvalid  = cpu_rvalid_q;
      // Out-of-range reads substitute zero for whatever the memory drives.
      disp_rdata  = (disp_rvalid_q && !disp_oor_q) ? mem_readdata : 8'h00;
      cpu_rdata   = (cpu_rvalid_q && !cpu_oor_q) ? mem_readdata : 8'h00;
   end

   // ------------------------------------------------------------------------
   // Memory-side outputs
   // ------------------------------------------------------------------------
   always_comb begin
      mem_address    = any_grant ? win_addr : addr_hold_q;
      mem_writedata  = any_grant ? cpu_wdata : wdata_hold_q;
      mem_chipselect = any_grant && win_in_range;
      // Out-of-range writes are acknowledged to the CPU but never reach memory.
      mem_write      = cpu_grant && cpu_write && cpu_in_range;
      mem_clken      = !reset;
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
         addr_hold_q  <= '0;
         wdata_hold_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         if (any_grant) begin
            addr_hold_q  <= win_addr;
            wdata_hold_q <= cpu_wdata;
         end
      end
   end

   // Clearing these asynchronously kills any read in flight when reset hits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_rvalid_q <= 1'b0;
         disp_oor_q    <= 1'b0;
         cpu_rvalid_q  <= 1'b0;
         cpu_oor_q     <= 1'b0;
      end else begin
         disp_rvalid_q <= disp_grant;
         disp_oor_q    <= disp_grant && !disp_in_range;
         cpu_rvalid_q  <= cpu_grant && !cpu_write;
         cpu_oor_q     <= cpu_grant && !cpu_write && !cpu_in_range;
      end
   end

endmodule

// File: tb/tb_background_mem_arbiter.sv
// Self-checking bench for background_mem_arbiter: directed scenarios followed
// by a randomized phase, all compared against a behavioural reference model.

module tb_background_mem_arbiter;

   localparam int DEPTH        = 307200;
   localparam int STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        disp_req;
   logic [18:0] disp_addr;
   logic        disp_ack;
   logic        disp_rvalid;
   logic [7:0]  disp_rdata;
   logic        cpu_req;
   logic        cpu_write;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_waitrequest;
   logic        cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic [18:0] mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [7:0]  mem_writedata;
   logic        mem_clken;
   logic [7:0]  mem_readdata;

   background_mem_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .disp_req        (disp_req),
      .disp_addr       (disp_addr),
      .disp_ack        (disp_ack),
      .disp_rvalid     (disp_rvalid),
      .disp_rdata      (disp_rdata),
      .cpu_req         (cpu_req),
      .cpu_write       (cpu_write),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_waitrequest (cpu_waitrequest),
      .cpu_rvalid      (cpu_rvalid),
      .cpu_rdata       (cpu_rdata),
      .mem_address     (mem_address),
      .mem_chipselect  (mem_chipselect),
      .mem_write       (mem_write),
      .mem_writedata   (mem_writedata),
      .mem_clken       (mem_clken),
      .mem_readdata    (mem_readdata)
   );

   always #5 clk = ~clk;

   // Memory device: synchronous read, drives noise when not selected.
   logic [7:0] mem [0:DEPTH-1] = '{default: 8'h00};
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) mem[mem_address] <= mem_writedata;
         mem_readdata <= mem[mem_address];
      end else begin
         mem_readdata <= 8'($urandom);
      end
   end

   // Reference model state
   logic [7:0]  shadow [0:DEPTH-1] = '{default: 8'h00};
   int          starve;
   logic [18:0] last_addr;
   logic [7:0]  last_wdata;
   logic        p_dv, p_cv;
   logic [7:0]  p_d, p_c;
   logic        last_cpu_grant;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      starve     = 0;
      last_addr  = '0;
      last_wdata = '0;
      p_dv = 1'b0; p_cv = 1'b0; p_d = '0; p_c = '0;
      last_cpu_grant = 1'b0;
   endtask

   // One clock cycle with the inputs currently driven: checks outputs at the
   // falling edge, advances the model at the rising edge, returns 1ns later.
   task automatic run_cycle();
      logic        cw, dw, win, inr;
      logic [18:0] a;
      @(negedge clk);
      cw  = cpu_req && (!disp_req || starve >= STARVE_LIMIT);
      dw  = disp_req && !cw;
      win = cw || dw;
      a   = cw ? cpu_addr : disp_addr;
      inr = int'(a) < DEPTH;
      check("disp_ack",        32'(disp_ack),        32'(dw));
      check("cpu_waitrequest", 32'(cpu_waitrequest), 32'(cpu_req && !cw));
      check("mem_chipselect",  32'(mem_chipselect),  32'(win && inr));
      check("mem_write",       32'(mem_write),       32'(cw && cpu_write && inr));
      check("mem_address",     32'(mem_address),     32'(win ? a : last_addr));
      check("mem_writedata",   32'(mem_writedata),   32'(win ? cpu_wdata : last_wdata));
      check("mem_clken",       32'(mem_clken),       32'd1);
      check("disp_rvalid",     32'(disp_rvalid),     32'(p_dv));
      check("disp_rdata",      32'(disp_rdata),      32'(p_d));
      check("cpu_rvalid",      32'(cpu_rvalid),      32'(p_cv));
      check("cpu_rdata",       32'(cpu_rdata),       32'(p_c));
      @(posedge clk);
      p_dv = dw;
      p_d  = (dw && inr) ? shadow[a] : 8'h00;
      p_cv = cw && !cpu_write;
      p_c  = (cw && !cpu_write && inr) ? shadow[a] : 8'h00;
      if (cw && cpu_write && inr) shadow[a] = cpu_wdata;
      if (cw) starve = 0;
      else if (dw && cpu_req) starve++;
      if (win) begin
         last_addr  = a;
         last_wdata = cpu_wdata;
      end
      last_cpu_grant = cw;
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"},
            32'({disp_ack, disp_rvalid, disp_rdata, cpu_rvalid, cpu_rdata,
                 mem_chipselect, mem_write, mem_clken, cpu_waitrequest}),
            32'h1);
      check({tag, "_addr"},  32'(mem_address),   32'd0);
      check({tag, "_wdata"}, 32'(mem_writedata), 32'd0);
   endtask

   // Asserts reset immediately (asynchronously), holds two cycles, releases.
   task automatic apply_reset();
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_entry");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      disp_req = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_op(input logic wr, input logic [18:0] addr, input logic [7:0] data);
      cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = data;
      run_cycle();
      cpu_req = 1'b0; cpu_write = 1'b0;
   endtask

   function automatic logic [18:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 19'($urandom_range(0, 31));
         1:       return 19'($urandom_range(DEPTH - 32, DEPTH - 1));
         2:       return 19'($urandom_range(DEPTH, DEPTH + 10));
         default: return 19'($urandom_range(32, 63));
      endcase
   endfunction

   initial begin
      int grants[$];
      reset = 1'b1;
      disp_req = 1'b0; disp_addr = '0;
      cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      model_clear();
      apply_reset();

      // Display-only read of a preloaded location
      cpu_op(1'b1, 19'h00010, 8'h5A);
      disp_req = 1'b1; disp_addr = 19'h00010;
      run_cycle();
      disp_req = 1'b0;
      check("disp_read_rvalid", 32'(disp_rvalid), 32'd1);
      check("disp_read_data",   32'(disp_rdata),  32'h5A);
      run_cycle();

      // CPU write then read of the last valid location
      cpu_op(1'b1, 19'h4AFFF, 8'hC3);
      cpu_op(1'b0, 19'h4AFFF, 8'h00);
      check("cpu_read_rvalid", 32'(cpu_rvalid), 32'd1);
      check("cpu_read_data",   32'(cpu_rdata),  32'hC3);
      run_cycle();

      // Out-of-range write and read
      cpu_op(1'b1, 19'h4B000, 8'hEE);
      cpu_op(1'b0, 19'h4B000, 8'h00);
      check("oor_rvalid", 32'(cpu_rvalid), 32'd1);
      check("oor_rdata",  32'(cpu_rdata),  32'h00);
      run_cycle();
      check("oor_mem_unchanged", 32'(mem[DEPTH-1]), 32'hC3);

      // Starvation: both held, CPU forced every STARVE_LIMIT+1 cycles
      apply_reset();
      disp_req = 1'b1; disp_addr = 19'h00020;
      cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 19'h00010;
      for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
         run_cycle();
         if (last_cpu_grant) grants.push_back(i);
      end
      disp_req = 1'b0; cpu_req = 1'b0;
      check("starve_grant_count", 32'(grants.size()), 32'd2);
      check("starve_first_cpu",   32'(grants[0]), 32'(STARVE_LIMIT));
      check("starve_second_cpu",  32'(grants[1]), 32'(2 * STARVE_LIMIT + 1));
      run_cycle();

      // Reset in the cycle after a display grant
      disp_req = 1'b1; disp_addr = 19'h00010;
      run_cycle();
      apply_reset();
      check("post_rst_rvalid", 32'(disp_rvalid), 32'd0);
      disp_req = 1'b1; disp_addr = 19'h00010;
      run_cycle();
      disp_req = 1'b0;
      check("post_rst_read", 32'(disp_rdata), 32'h5A);
      run_cycle();

      // Randomized traffic; the CPU holds a request until it is accepted
      for (int i = 0; i < 600; i++) begin
         disp_req  = ($urandom_range(0, 3) != 0);
         disp_addr = rand_addr();
         if (!(cpu_req && !last_cpu_grant)) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_write = $urandom_range(0, 1) == 1;
            cpu_addr  = rand_addr();
            cpu_wdata = 8'($urandom);
         end
         run_cycle();
      end
      disp_req = 1'b0; cpu_req = 1'b0;
      run_cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
